// File: rtl/id_fwd_stage_pkg.sv
// Shared constants for the LA32R decode/forwarding stage: producer bus layout,
// id_reg field offsets, ALU op indices and opcode encodings.
package cpu_pkg;

  // Producer bus: {valid, gr_we, ready, dest[4:0], data[31:0]}
  localparam int unsigned FWD_W         = 40;
  localparam int unsigned FWD_VALID_BIT = 39;
  localparam int unsigned FWD_WE_BIT    = 38;
  localparam int unsigned FWD_RDY_BIT   = 37;
  localparam int unsigned FWD_DEST_LSB  = 32;
  localparam int unsigned FWD_DATA_LSB  = 0;

  // id_reg layout
  localparam int unsigned ID_ALU_OP_LSB   = 140;
  localparam int unsigned ID_RES_FROM_MEM = 139;
  localparam int unsigned ID_NEED_UI5     = 138;
  localparam int unsigned ID_SRC1_IS_PC   = 137;
  localparam int unsigned ID_SRC2_IS_IMM  = 136;
  localparam int unsigned ID_SRC2_IS_4    = 135;
  localparam int unsigned ID_GR_WE        = 134;
  localparam int unsigned ID_MEM_WE       = 133;
  localparam int unsigned ID_DEST_LSB     = 128;
  localparam int unsigned ID_IMM_LSB      = 96;
  localparam int unsigned ID_RJ_LSB       = 64;
  localparam int unsigned ID_RKD_LSB      = 32;
  localparam int unsigned ID_PC_LSB       = 0;

  // ALU op one-hot indices
  localparam int unsigned ALU_OP_W = 12;
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  // Opcode fields
  localparam logic [5:0] OP6_SPECIAL = 6'h00;
  localparam logic [5:0] OP6_LU12I   = 6'h05;
  localparam logic [5:0] OP6_MEM     = 6'h0a;
  localparam logic [5:0] OP6_JIRL    = 6'h13;
  localparam logic [5:0] OP6_B       = 6'h14;
  localparam logic [5:0] OP6_BL      = 6'h15;
  localparam logic [5:0] OP6_BEQ     = 6'h16;
  localparam logic [5:0] OP6_BNE     = 6'h17;
  localparam logic [3:0] OP4_ALU     = 4'h0;
  localparam logic [3:0] OP4_SHIFT   = 4'h1;
  localparam logic [3:0] OP4_LDW     = 4'h2;
  localparam logic [3:0] OP4_STW     = 4'h6;
  localparam logic [3:0] OP4_ADDI    = 4'ha;
  localparam logic [1:0] OP2_SHIFT   = 2'h0;
  localparam logic [1:0] OP2_3R      = 2'h1;
  localparam logic [4:0] OP5_ADD     = 5'h00;
  localparam logic [4:0] OP5_SUB     = 5'h02;
  localparam logic [4:0] OP5_SLT     = 5'h04;
  localparam logic [4:0] OP5_SLTU    = 5'h05;
  localparam logic [4:0] OP5_NOR     = 5'h08;
  localparam logic [4:0] OP5_AND     = 5'h09;
  localparam logic [4:0] OP5_OR      = 5'h0a;
  localparam logic [4:0] OP5_XOR     = 5'h0b;
  localparam logic [4:0] OP5_SLLI    = 5'h01;
  localparam logic [4:0] OP5_SRLI    = 5'h09;
  localparam logic [4:0] OP5_SRAI    = 5'h11;

endpackage

// File: rtl/id_fwd_stage_if.sv
// IF/ID/EX handshake, writeback and producer buses of the decode stage.
interface id_fwd_stage_if #(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned FWD_W   = 40
);
  logic                       ex_allowin;
  logic                       id_allowin;
  logic                       if_to_id_valid;
  logic [63:0]                if_reg;
  logic                       id_to_ex_valid;
  logic [151:0]               id_reg;
  logic [32:0]                branch_reg;
  logic                       br_taken_cancel;
  logic [37:0]                wb_to_rf_reg;
  logic [NUM_FWD*FWD_W-1:0]   fwd_bus;

  modport master (
    input  ex_allowin, if_to_id_valid, if_reg, wb_to_rf_reg, fwd_bus,
    output id_allowin, id_to_ex_valid, id_reg, branch_reg, br_taken_cancel
  );

  modport slave (
    output ex_allowin, if_to_id_valid, if_reg, wb_to_rf_reg, fwd_bus,
    input  id_allowin, id_to_ex_valid, id_reg, branch_reg, br_taken_cancel
  );
endinterface

// File: rtl/id_fwd_stage_fwd_sel.sv
// Per-source operand selection across the producer buses.
module fwd_sel #(
  parameter int unsigned NUM_FWD = 3,
  parameter bit          FWD_EN  = 1'b1,
  parameter int unsigned FWD_W   = cpu_pkg::FWD_W
) (
  input  logic [4:0]               s_i,
  input  logic                     s_en_i,
  input  logic [NUM_FWD*FWD_W-1:0] fwd_bus_i,
  input  logic [31:0]              rf_rdata_i,
  output logic [31:0]              value_o,
  output logic                     hazard_o
);
  import cpu_pkg::*;

  logic             found;
  logic [FWD_W-1:0] slice;

  // Youngest-first scan: the first match decides, so an older ready producer
  // can never mask a younger one that is still computing.
  always_comb begin
    value_o  = rf_rdata_i;
    hazard_o = 1'b0;
    found    = 1'b0;
    slice    = '0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      slice = fwd_bus_i[i*FWD_W +: FWD_W];
      if (!found && slice[FWD_VALID_BIT] && slice[FWD_WE_BIT] &&
          slice[FWD_DEST_LSB +: 5] != 5'd0 && s_en_i &&
          slice[FWD_DEST_LSB +: 5] == s_i) begin
        found = 1'b1;
        if (FWD_EN && slice[FWD_RDY_BIT]) value_o  = slice[FWD_DATA_LSB +: 32];
        else                              hazard_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/id_fwd_stage.sv
// LA32R decode/register-read stage with a forwarding network and stall-on-unready.
module id_fwd_stage #(
  parameter int unsigned NUM_FWD = 3,
  parameter bit          FWD_EN  = 1'b1,
  parameter int unsigned FWD_W   = cpu_pkg::FWD_W
) (
  input  logic          clk,
  input  logic          reset,
  id_fwd_stage_if.master bus
);
  import cpu_pkg::*;

  logic        id_valid_q, id_valid_d;
  logic [63:0] if_reg_q;
  logic [31:0] rf_q [32];

  logic [31:0] inst, pc;
  logic [5:0]  op_31_26;
  logic [3:0]  op_25_22;
  logic [1:0]  op_21_20;
  logic [4:0]  op_19_15, rd, rj, rk;
  logic [11:0] i12;
  logic [19:0] i20;
  logic [15:0] i16;
  logic [25:0] i26;
  logic [63:0] d31_26;
  logic [15:0] d25_22;
  logic [3:0]  d21_20;
  logic [31:0] d19_15;
  logic        unused_ok;

  logic is_3r, is_sh;
  logic inst_add, inst_sub, inst_slt, inst_sltu, inst_nor, inst_and, inst_or, inst_xor;
  logic inst_slli, inst_srli, inst_srai, inst_addi, inst_ld, inst_st;
  logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne, inst_lu12i;

  logic [ALU_OP_W-1:0] alu_op;
  logic        src2_is_4, gr_we, rs1_en, rs2_en;
  logic [4:0]  rs2, dest;
  logic [31:0] imm, br_offs, jirl_offs, br_target;
  logic [31:0] rf_rdata1, rf_rdata2, rj_value, rkd_value;
  logic        rs1_hazard, rs2_hazard, id_ready_go, id_allowin;
  logic        br_cond, br_taken, br_taken_cancel;
  logic [151:0] id_bits;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign inst     = if_reg_q[63:32];
  assign pc       = if_reg_q[31:0];
  assign op_31_26 = inst[31:26];
  assign op_25_22 = inst[25:22];
  assign op_21_20 = inst[21:20];
  assign op_19_15 = inst[19:15];
  assign rd       = inst[4:0];
  assign rj       = inst[9:5];
  assign rk       = inst[14:10];
  assign i12      = inst[21:10];
  assign i20      = inst[24:5];
  assign i16      = inst[25:10];
  assign i26      = {inst[9:0], inst[25:10]};

  assign d31_26   = 64'd1 << op_31_26;
  assign d25_22   = 16'd1 << op_25_22;
  assign d21_20   = 4'd1 << op_21_20;
  assign d19_15   = 32'd1 << op_19_15;
  assign unused_ok = ^{d31_26, d25_22, d21_20, d19_15};

  assign is_3r      = d31_26[OP6_SPECIAL] & d25_22[OP4_ALU] & d21_20[OP2_3R];
  assign is_sh      = d31_26[OP6_SPECIAL] & d25_22[OP4_SHIFT] & d21_20[OP2_SHIFT];
  assign inst_add   = is_3r & d19_15[OP5_ADD];
  assign inst_sub   = is_3r & d19_15[OP5_SUB];
  assign inst_slt   = is_3r & d19_15[OP5_SLT];
  assign inst_sltu  = is_3r & d19_15[OP5_SLTU];
  assign inst_nor   = is_3r & d19_15[OP5_NOR];
  assign inst_and   = is_3r & d19_15[OP5_AND];
  assign inst_or    = is_3r & d19_15[OP5_OR];
  assign inst_xor   = is_3r & d19_15[OP5_XOR];
  assign inst_slli  = is_sh & d19_15[OP5_SLLI];
  assign inst_srli  = is_sh & d19_15[OP5_SRLI];
  assign inst_srai  = is_sh & d19_15[OP5_SRAI];
  assign inst_addi  = d31_26[OP6_SPECIAL] & d25_22[OP4_ADDI];
  assign inst_ld    = d31_26[OP6_MEM] & d25_22[OP4_LDW];
  assign inst_st    = d31_26[OP6_MEM] & d25_22[OP4_STW];
  assign inst_jirl  = d31_26[OP6_JIRL];
  assign inst_b     = d31_26[OP6_B];
  assign inst_bl    = d31_26[OP6_BL];
  assign inst_beq   = d31_26[OP6_BEQ];
  assign inst_bne   = d31_26[OP6_BNE];
  assign inst_lu12i = d31_26[OP6_LU12I] & ~inst[25];

  // ALU operation one-hot
  always_comb begin
    alu_op           = '0;
    alu_op[ALU_ADD]  = inst_add | inst_addi | inst_ld | inst_st | inst_jirl | inst_bl;
    alu_op[ALU_SUB]  = inst_sub;
    alu_op[ALU_SLT]  = inst_slt;
    alu_op[ALU_SLTU] = inst_sltu;
    alu_op[ALU_AND]  = inst_and;
    alu_op[ALU_NOR]  = inst_nor;
    alu_op[ALU_OR]   = inst_or;
    alu_op[ALU_XOR]  = inst_xor;
    alu_op[ALU_SLL]  = inst_slli;
    alu_op[ALU_SRL]  = inst_srli;
    alu_op[ALU_SRA]  = inst_srai;
    alu_op[ALU_LUI]  = inst_lu12i;
  end

  assign src2_is_4 = inst_jirl | inst_bl;
  assign gr_we     = ~inst_st & ~inst_beq & ~inst_bne & ~inst_b;
  assign dest      = inst_bl ? 5'd1 : rd;
  assign rs1_en    = ~(inst_b | inst_bl | inst_lu12i);
  assign rs2_en    = is_3r | inst_beq | inst_bne | inst_st;
  assign rs2       = (inst_beq | inst_bne | inst_st) ? rd : rk;
  assign imm       = src2_is_4  ? 32'd4 :
                     inst_lu12i ? {i20, 12'b0} : {{20{i12[11]}}, i12};
  assign br_offs   = (inst_b | inst_bl) ? {{4{i26[25]}}, i26, 2'b00}
                                        : {{14{i16[15]}}, i16, 2'b00};
  assign jirl_offs = {{14{i16[15]}}, i16, 2'b00};

  // Regfile write port; r0 is forced to zero on the read side
  assign {rf_we, rf_waddr, rf_wdata} = bus.wb_to_rf_reg;
  always_ff @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = (rj  == 5'd0) ? '0 : rf_q[rj];
  assign rf_rdata2 = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  fwd_sel #(.NUM_FWD(NUM_FWD), .FWD_EN(FWD_EN), .FWD_W(FWD_W)) u_fwd_rs1 (
    .s_i(rj), .s_en_i(rs1_en), .fwd_bus_i(bus.fwd_bus), .rf_rdata_i(rf_rdata1),
    .value_o(rj_value), .hazard_o(rs1_hazard)
  );
  fwd_sel #(.NUM_FWD(NUM_FWD), .FWD_EN(FWD_EN), .FWD_W(FWD_W)) u_fwd_rs2 (
    .s_i(rs2), .s_en_i(rs2_en), .fwd_bus_i(bus.fwd_bus), .rf_rdata_i(rf_rdata2),
    .value_o(rkd_value), .hazard_o(rs2_hazard)
  );

  assign id_ready_go     = ~(rs1_hazard | rs2_hazard);
  assign id_allowin      = ~id_valid_q | (id_ready_go & bus.ex_allowin);
  assign br_cond         = (inst_beq & (rj_value == rkd_value)) |
                           (inst_bne & (rj_value != rkd_value)) |
                           inst_jirl | inst_bl | inst_b;
  assign br_taken        = br_cond & id_valid_q & id_ready_go;
  assign br_taken_cancel = br_taken;
  assign br_target       = inst_jirl ? (rj_value + jirl_offs) : (pc + br_offs);

  // id_reg assembly
  always_comb begin
    id_bits                                = '0;
    id_bits[ID_ALU_OP_LSB +: ALU_OP_W]     = alu_op;
    id_bits[ID_RES_FROM_MEM]               = inst_ld;
    id_bits[ID_NEED_UI5]                   = inst_slli | inst_srli | inst_srai;
    id_bits[ID_SRC1_IS_PC]                 = inst_jirl | inst_bl;
    id_bits[ID_SRC2_IS_IMM]                = inst_slli | inst_srli | inst_srai | inst_addi |
                                             inst_ld | inst_st | inst_lu12i | inst_jirl | inst_bl;
    id_bits[ID_SRC2_IS_4]                  = src2_is_4;
    id_bits[ID_GR_WE]                      = gr_we;
    id_bits[ID_MEM_WE]                     = inst_st;
    id_bits[ID_DEST_LSB +: 5]              = dest;
    id_bits[ID_IMM_LSB +: 32]              = imm;
    id_bits[ID_RJ_LSB +: 32]               = rj_value;
    id_bits[ID_RKD_LSB +: 32]              = rkd_value;
    id_bits[ID_PC_LSB +: 32]               = pc;
  end

  // id_valid next state: a redirect beats any incoming instruction
  always_comb begin
    id_valid_d = id_valid_q;
    if (br_taken_cancel)  id_valid_d = 1'b0;
    else if (id_allowin)  id_valid_d = bus.if_to_id_valid;
  end

  // id_valid register
  always_ff @(posedge clk) begin
    if (reset) id_valid_q <= 1'b0;
    else       id_valid_q <= id_valid_d;
  end

  // Instruction register, intentionally not reset
  always_ff @(posedge clk) begin
    if (bus.if_to_id_valid && id_allowin) if_reg_q <= bus.if_reg;
  end

  assign bus.id_allowin      = id_allowin;
  assign bus.id_to_ex_valid  = id_valid_q & id_ready_go;
  assign bus.id_reg          = id_bits;
  assign bus.branch_reg      = {br_taken, br_target};
  assign bus.br_taken_cancel = br_taken_cancel;
endmodule

// File: doc/id_fwd_stage.md
# id_fwd_stage

Decode/register-read stage for the 5-stage LA32R pipeline, successor to the stall-only decode stage. Sits between the IF and EX stages. Resolves RAW hazards through a parametrised forwarding network with NUM_FWD producer stages, and stalls only when the youngest matching producer has no result yet (for example, load-use). FWD_EN=0 selects the legacy mode, in which every RAW match stalls.

## Interface
- NUM_FWD, 3, number of forwarding producers; index 0 is the youngest (EX), then MEM, then WB.
- FWD_EN, 1, 1 = forward when the producer is ready; 0 = stall on any match.
- FWD_W, 40, width of one producer bus: {valid[39], gr_we[38], ready[37], dest[36:32], data[31:0]}.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high.
- ex_allowin  in  1  EX can accept an instruction.
- id_allowin  out  1  `!id_valid || (id_ready_go && ex_allowin)`.
- if_to_id_valid  in  1  IF holds a valid instruction.
- if_reg  in  64  {inst[63:32], pc[31:0]}.
- id_to_ex_valid  out  1  `id_valid && id_ready_go`.
- id_reg  out  152  {alu_op[151:140], res_from_mem, need_ui5, src1_is_pc, src2_is_imm, src2_is_4, gr_we, mem_we, dest[132:128], imm[127:96], rj_value[95:64], rkd_value[63:32], pc[31:0]}.
- branch_reg  out  33  {br_taken, br_target}.
- br_taken_cancel  out  1  branch redirect; flushes IF.
- wb_to_rf_reg  in  38  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- fwd_bus  in  NUM_FWD*FWD_W  producer buses; slice i is at [i*FWD_W +: FWD_W].

## Operation
- Instruction set: add.w, sub.w, slt, sltu, nor, and, or, xor, slli.w, srli.w, srai.w, addi.w, ld.w, st.w, jirl, b, bl, beq, bne, lu12i.w.
- Decode uses the 6-64, 4-16, 2-4 and 5-32 one-hot decoders.
- Source enables:
  - rs1 = rj. It is used by all instructions except b, bl and lu12i.w.
  - rs2 = rd for beq, bne and st.w; otherwise rk. It is used by the 3R ALU ops, beq, bne and st.w.
- Match condition for source s against producer i: `valid_i && gr_we_i && dest_i != 0 && s_en && s == dest_i`.
- Selection is per source. The lowest matching index wins. If no producer matches, the regfile value is used.
- FWD_EN=1: the operand takes the winner's data if the winner has ready=1. If the winner has ready=0, hazard is set. An older ready producer never overrides a younger unready one.
- FWD_EN=0: any match sets hazard, and the regfile value is used.
- `id_ready_go = !hazard`.
- Branch resolution uses the forwarded operands:
  - beq/bne compare rj_value against rkd_value.
  - br_target = pc + offs for b, bl, beq and bne; rj_value + (si16 << 2) for jirl.
  - `br_taken_cancel = br_taken && id_valid && id_ready_go`.
  - br_taken is forced to 0 while stalled.
- Regfile: 32x32, r0 reads 0.
  - Reads are combinational.
  - A same-cycle WB write to a register being read is covered by the WB producer slice, not by regfile write-through.

## Timing
- Reset values:
  - id_valid = 0.
  - Therefore id_to_ex_valid = 0, br_taken_cancel = 0, branch_reg[32] = 0, id_allowin = 1.
  - The instruction register is not reset.
- Per-edge priority for id_valid: reset → 0; else br_taken_cancel → 0; else if id_allowin → if_to_id_valid.
- The instruction register loads when `if_to_id_valid && id_allowin`.
- Latency is one cycle when there is no hazard. All outputs are combinational from the registered instruction and the live producer buses.
- While stalled:
  - id_reg and branch outputs are held.
  - id_allowin = 0 and IF must hold.
  - The stage releases in the same cycle that the blocking producer shows ready=1 or drops its match.
- ex_allowin=0 with id_ready_go=1: no transfer; id_valid and the instruction register are held.
- A cancel that coincides with an incoming if_to_id_valid: the incoming instruction is dropped, and id_valid = 0 next cycle.
- Reset mid-stall: the stall clears next cycle, and no id_to_ex_valid pulse occurs.

## Structure
- Package `cpu_pkg`:
  - FWD_W and the field offsets of the producer bus.
  - id_reg field offsets.
  - ALU_OP index constants: ADD=0 … LUI=11.
  - Opcode constants.
- Sub-module `fwd_sel`: one instance per source. Inputs are s, s_en, fwd_bus and rf_rdata. Outputs are value and hazard. Parametrised by NUM_FWD and FWD_EN.
- Reuses the existing regfile and decoder modules.

## Test plan
1. FWD_EN=1, `add.w r3,r1,r2` in ID, EX slice {1,1,1,r1,0x10}, regfile r2=5 → rj_value=0x10, rkd_value=5, id_ready_go=1, id_to_ex_valid=1.
2. EX = ld.w→r4 with ready=0, MEM = ready producer of r4=0x99, ID = `addi.w r5,r4,1` → stall (id_allowin=0). Next cycle MEM slice {r4,ready,0x77} → rj_value=0x77, released.
3. FWD_EN=0, WB slice matching rj=r7 → stall for the full cycle, matching the legacy behaviour. With dest=r0 → no stall.
4. `beq r1,r2,+8` at pc 0x1C000000, r1 forwarded 3 from MEM, r2=3 from regfile → br_taken_cancel=1, br_target=0x1C000020, id_valid=0 next cycle.
5. bne with its source blocked by an unready EX producer → br_taken_cancel=0 until ready, then fires once.
6. reset asserted during a stall → id_to_ex_valid=0 and id_allowin=1 on the next cycle.
